// File: rtl/noc_inject_arbiter.sv
// ============================================================================
// noc_inject_arbiter
//
// Purpose:
//   Shares one NoC injection port (putFlit / getCredits) among NUM_REQ local
//   flit sources. Arbitration is round-robin and packet-atomic: a source that
//   wins with a non-tail flit keeps the port until it sends its tail flit.
//   Each virtual channel has its own credit counter. A flit is only accepted
//   when the VC it will travel on holds at least one credit.
//
// Optional feature (compile-time macro):
//   INJ_STALL_CNT_EN  - when defined, adds the 32-bit output o_stall_cycles.
//                       It counts the cycles in which some source is valid
//                       but nothing is transferred, and saturates at all-ones.
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_reset          synchronous active-high reset
//   i_req_valid      per-source flit valid               [NUM_REQ]
//   i_req_tail       per-source tail flag                [NUM_REQ]
//   i_req_dest       per-source destination, slice i at  [i*DEST_BITS +: DEST_BITS]
//   i_req_vc         per-source VC, used on head flits   [i*VC_BITS +: VC_BITS]
//   i_req_data       per-source payload                  [i*FLIT_DATA_WIDTH +: ...]
//   o_req_ready      combinational accept, at most one bit high
//   o_putFlit        registered flit {valid, tail, dest, vc, data}
//   o_EN_putFlit     one-cycle strobe per injected flit
//   i_getCredits     credit return {valid, vc}
//   o_EN_getCredits  credit-accept enable, high from the cycle after reset
//   o_grant_id       current or most recent owner
//   o_busy           high while a packet holds the port
//   o_stall_cycles   stall counter (only with INJ_STALL_CNT_EN)
// ============================================================================
module noc_inject_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int NUM_VCS         = 2,
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int DEST_BITS       = 5,
    parameter int BUF_DEPTH       = 16,
    localparam int VC_BITS        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int FLIT_W         = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH,
    localparam int CNT_W          = $clog2(BUF_DEPTH) + 1,
    localparam int GID_W          = $clog2(NUM_REQ)
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [NUM_REQ-1:0]                 i_req_tail,
    input  logic [NUM_REQ*DEST_BITS-1:0]       i_req_dest,
    input  logic [NUM_REQ*VC_BITS-1:0]         i_req_vc,
    input  logic [NUM_REQ*FLIT_DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    output logic [FLIT_W-1:0]                  o_putFlit,
    output logic                               o_EN_putFlit,
    input  logic [VC_BITS:0]                   i_getCredits,
    output logic                               o_EN_getCredits,
    output logic [GID_W-1:0]                   o_grant_id,
    output logic                               o_busy
`ifdef INJ_STALL_CNT_EN
    ,
    output logic [31:0]                        o_stall_cycles
`endif
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_nextState;

    logic [GID_W-1:0]           r_lastGrant;
    logic [GID_W-1:0]           r_grantId;
    logic [VC_BITS-1:0]         r_curVc;
    logic [CNT_W-1:0]           r_credit [NUM_VCS];
    logic [FLIT_W-1:0]          r_putFlit;
    logic                       r_enPut;
    logic                       r_enGet;

    logic [DEST_BITS-1:0]       w_dest  [NUM_REQ];
    logic [VC_BITS-1:0]         w_vcIn  [NUM_REQ];
    logic [FLIT_DATA_WIDTH-1:0] w_data  [NUM_REQ];

    logic [(1<<VC_BITS)-1:0]    w_vcHasCredit;
    logic [NUM_REQ-1:0]         w_eligible;
    logic                       w_found;
    logic [GID_W-1:0]           w_winner;
    logic [GID_W-1:0]           w_scanIdx;

    logic [NUM_REQ-1:0]         w_ready;
    logic [GID_W-1:0]           w_selIdx;
    logic [VC_BITS-1:0]         w_vcUsed;
    logic                       w_xfer;
    logic                       w_xferTail;

    logic [NUM_VCS-1:0]         w_dec;
    logic [NUM_VCS-1:0]         w_inc;

    // Split the flat per-source buses into arrays so the selected source can
    // be picked with a plain array index instead of computed part-selects.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_dest[i] = i_req_dest[i*DEST_BITS +: DEST_BITS];
        assign w_vcIn[i] = i_req_vc[i*VC_BITS +: VC_BITS];
        assign w_data[i] = i_req_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
    end

    // One "has a credit" flag for every encodable VC number. Encodings past
    // NUM_VCS never have a credit, so a source naming a non-existent VC is
    // simply never eligible.
    for (genvar v = 0; v < (1 << VC_BITS); v++) begin : g_vcFlag
        if (v < NUM_VCS) begin : g_real
            assign w_vcHasCredit[v] = (r_credit[v] != '0);
        end else begin : g_absent
            assign w_vcHasCredit[v] = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign w_eligible[i] = i_req_valid[i] & w_vcHasCredit[w_vcIn[i]];
    end

    // Round-robin search: start one past the last owner, wrap around, and
    // take the first eligible source. The last owner is checked last, so a
    // different eligible source always wins after a packet completes.
    always_comb begin
        w_found   = 1'b0;
        w_winner  = '0;
        w_scanIdx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scanIdx = GID_W'((int'(r_lastGrant) + k) % NUM_REQ);
            if (!w_found && w_eligible[w_scanIdx]) begin
                w_found  = 1'b1;
                w_winner = w_scanIdx;
            end
        end
    end

    // State register of the IDLE / LOCKED machine.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a non-tail flit accepted in IDLE locks the port to its
    // source, and a tail flit accepted while locked releases it. A
    // single-flit packet (head is also the tail) never leaves IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !w_xferTail) begin
                    w_nextState = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_xferTail) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Outputs of the state machine. In IDLE the arbiter winner is offered the
    // port and its own VC is used. While locked only the owner may be ready,
    // and body flits travel on the VC captured from the head. Nothing is
    // ready while reset is held, so no flit can be accepted during reset.
    always_comb begin
        w_ready  = '0;
        w_selIdx = r_grantId;
        w_vcUsed = r_curVc;
        o_busy   = (r_state == ST_LOCKED);
        case (r_state)
            ST_IDLE: begin
                w_selIdx = w_winner;
                w_vcUsed = w_vcIn[w_winner];
                if (w_found && !i_reset) begin
                    w_ready[w_winner] = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!i_reset) begin
                    w_ready[r_grantId] = i_req_valid[r_grantId] & w_vcHasCredit[r_curVc];
                end
            end
            default: begin
                w_ready = '0;
            end
        endcase
    end

    assign o_req_ready = w_ready;
    assign w_xfer      = |(i_req_valid & w_ready);
    assign w_xferTail  = i_req_tail[w_selIdx];

    // Ownership bookkeeping. Only a head flit accepted in IDLE changes the
    // owner; last grant starts at the top index so requester 0 wins first
    // after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lastGrant <= GID_W'(NUM_REQ - 1);
            r_grantId   <= '0;
            r_curVc     <= '0;
        end else if ((r_state == ST_IDLE) && w_xfer) begin
            r_lastGrant <= w_winner;
            r_grantId   <= w_winner;
            r_curVc     <= w_vcUsed;
        end
    end

    // Per-VC credit events for this cycle: a sent flit consumes one credit
    // on the VC it used; a valid credit return adds one to the VC it names.
    // Returns naming a VC past NUM_VCS match no counter and are ignored.
    always_comb begin
        w_dec = '0;
        w_inc = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            w_dec[v] = w_xfer && (int'(w_vcUsed) == v);
            w_inc[v] = i_getCredits[VC_BITS] && (int'(i_getCredits[VC_BITS-1:0]) == v);
        end
    end

    // Credit counters. A send and a return on the same VC cancel out.
    // Returns beyond the downstream buffer depth are dropped. A decrement
    // from zero cannot happen because ready already requires a credit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_credit[v] <= CNT_W'(BUF_DEPTH);
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_dec[v] && !w_inc[v]) begin
                    r_credit[v] <= r_credit[v] - CNT_W'(1);
                end else if (w_inc[v] && !w_dec[v] && (r_credit[v] != CNT_W'(BUF_DEPTH))) begin
                    r_credit[v] <= r_credit[v] + CNT_W'(1);
                end
            end
        end
    end

    // Output flit register: an accepted flit appears one cycle later with
    // its valid bit set. In idle cycles the last flit is kept and only its
    // valid bit drops, which avoids toggling the wide payload needlessly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_putFlit <= '0;
            r_enPut   <= 1'b0;
        end else begin
            r_enPut <= w_xfer;
            if (w_xfer) begin
                r_putFlit <= {1'b1, w_xferTail, w_dest[w_selIdx], w_vcUsed, w_data[w_selIdx]};
            end else begin
                r_putFlit[FLIT_W-1] <= 1'b0;
            end
        end
    end

    // Credit acceptance is enabled from the first cycle after reset onward.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_enGet <= 1'b0;
        end else begin
            r_enGet <= 1'b1;
        end
    end

    assign o_putFlit       = r_putFlit;
    assign o_EN_putFlit    = r_enPut;
    assign o_EN_getCredits = r_enGet;
    assign o_grant_id      = r_grantId;

`ifdef INJ_STALL_CNT_EN
    logic [31:0] r_stallCycles;

    // Counts cycles where some source wants the port but nothing moves,
    // whether that is lack of credit or a locked owner holding the port.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stallCycles <= '0;
        end else if ((|i_req_valid) && !w_xfer && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stallCycles;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// ============================================================================
// tb_noc_inject_arbiter
//
// Directed bench for noc_inject_arbiter with default parameters. Each
// stimulus cycle states which source must be ready. When an accept is
// expected, the flit that must appear one cycle later is queued. A separate
// monitor pops that queue whenever the DUT strobes EN_putFlit and compares
// the flit contents and its arrival cycle.
// ============================================================================
module tb_noc_inject_arbiter;

    localparam int NR  = 4;
    localparam int VCB = 1;
    localparam int DB  = 5;
    localparam int DW  = 64;
    localparam int FW  = 2 + DB + VCB + DW;
    localparam int GW  = 2;

    typedef struct {
        logic [FW-1:0] flit;
        int            cycle;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     reqValid;
    logic [NR-1:0]     reqTail;
    logic [NR*DB-1:0]  reqDest;
    logic [NR*VCB-1:0] reqVc;
    logic [NR*DW-1:0]  reqData;
    logic [NR-1:0]     reqReady;
    logic [FW-1:0]     putFlit;
    logic              enPutFlit;
    logic [VCB:0]      getCredits;
    logic              enGetCredits;
    logic [GW-1:0]     grantId;
    logic              busy;
`ifdef INJ_STALL_CNT_EN
    logic [31:0]       stallCycles;
`endif

    int   numChecks  = 0;
    int   numErrors  = 0;
    int   cycleCnt   = 0;
    bit   monitorOn  = 1'b0;
    exp_t expQ[$];
    exp_t monE;

    noc_inject_arbiter dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_req_valid     (reqValid),
        .i_req_tail      (reqTail),
        .i_req_dest      (reqDest),
        .i_req_vc        (reqVc),
        .i_req_data      (reqData),
        .o_req_ready     (reqReady),
        .o_putFlit       (putFlit),
        .o_EN_putFlit    (enPutFlit),
        .i_getCredits    (getCredits),
        .o_EN_getCredits (enGetCredits),
        .o_grant_id      (grantId),
        .o_busy          (busy)
`ifdef INJ_STALL_CNT_EN
        ,
        .o_stall_cycles  (stallCycles)
`endif
    );

    // Free-running clock and a cycle counter used to timestamp flits.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // Safety net so a broken DUT can never stall the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every comparison goes through here so the counts stay consistent.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        numChecks++;
        if (act !== req) begin
            numErrors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cycleCnt);
        end
    endtask

    function automatic logic [DB-1:0] mkDest(input int src, input int cyc);
        return DB'(src * 7 + 3 + cyc);
    endfunction

    function automatic logic [DW-1:0] mkData(input int src, input int cyc);
        return {8'(src), 24'hC0FFEE, 32'(cyc)};
    endfunction

    // Drives one cycle of inputs (entered just after a rising edge), checks
    // the combinational ready vector mid-cycle, queues the expected flit for
    // the source that must be accepted, and advances to the next cycle.
    task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR-1:0] tail,
                                 input logic [NR-1:0] vcs, input logic credV, input logic credVc,
                                 input logic [NR-1:0] expReady, input logic expVc);
        int   idx;
        exp_t e;
        reqValid = valid;
        reqTail  = tail;
        reqVc    = vcs;
        for (int i = 0; i < NR; i++) begin
            reqDest[i*DB +: DB] = mkDest(i, cycleCnt);
            reqData[i*DW +: DW] = mkData(i, cycleCnt);
        end
        getCredits = {credV, credVc};
        #3;
        checkOutput("req_ready", 128'(reqReady), 128'(expReady));
        if (expReady != '0) begin
            idx = 0;
            for (int i = 0; i < NR; i++) begin
                if (expReady[i]) idx = i;
            end
            e.flit  = {1'b1, tail[idx], mkDest(idx, cycleCnt), expVc, mkData(idx, cycleCnt)};
            e.cycle = cycleCnt + 1;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    // Holds reset for two cycles, then checks the credit-enable turn-on.
    task automatic doReset();
        reset      = 1'b1;
        reqValid   = '0;
        reqTail    = '0;
        reqVc      = '0;
        getCredits = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        checkOutput("EN_getCredits_release_cycle", 128'(enGetCredits), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("EN_getCredits_after_release", 128'(enGetCredits), 128'(1));
    endtask

    // Monitor: the valid bit of putFlit must track EN_putFlit, and each
    // strobe must match the oldest queued flit and arrive on its due cycle.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("putFlit_valid_bit", 128'(putFlit[FW-1]), 128'(enPutFlit));
            if (enPutFlit === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_flit", 128'(1), 128'(0));
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("putFlit", 128'(putFlit), 128'(monE.flit));
                    checkOutput("flit_latency", 128'(cycleCnt), 128'(monE.cycle));
                end
            end
        end
    end

    initial begin
        // Reset state, with every source asserting valid to prove ready
        // stays low while reset is held.
        reset      = 1'b1;
        reqValid   = '1;
        reqTail    = '1;
        reqVc      = '0;
        reqDest    = '0;
        reqData    = '0;
        getCredits = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        monitorOn = 1'b1;
        checkOutput("reset_req_ready", 128'(reqReady), 128'(0));
        checkOutput("reset_EN_putFlit", 128'(enPutFlit), 128'(0));
        checkOutput("reset_putFlit", 128'(putFlit), 128'(0));
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_grant_id", 128'(grantId), 128'(0));
        checkOutput("reset_EN_getCredits", 128'(enGetCredits), 128'(0));
        reset    = 1'b0;
        reqValid = '0;
        checkOutput("EN_getCredits_release_cycle", 128'(enGetCredits), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("EN_getCredits_after_release", 128'(enGetCredits), 128'(1));

        // Single-flit packets from sources 0 and 2 alternate 0,2,0,2.
        applyStimulus(4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        checkOutput("rr_grant_1", 128'(grantId), 128'(0));
        applyStimulus(4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0);
        checkOutput("rr_grant_2", 128'(grantId), 128'(2));
        applyStimulus(4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        checkOutput("rr_grant_3", 128'(grantId), 128'(0));
        applyStimulus(4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0);
        checkOutput("rr_grant_4", 128'(grantId), 128'(2));
        idleCycles(2);

        // Ten-flit packet from source 1 on VC 1 while source 3 waits. Body
        // flits present VC 0 on req_vc and must still travel on VC 1.
        doReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b1010, {1'b1, 1'b0, (k == 9), 1'b0}, {2'b00, (k == 0), 1'b0},
                          1'b0, 1'b0, 4'b0010, 1'b1);
            checkOutput("lock_busy", 128'(busy), 128'(k != 9));
            checkOutput("lock_grant_id", 128'(grantId), 128'(1));
        end
        applyStimulus(4'b1010, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0);
        checkOutput("after_tail_busy", 128'(busy), 128'(0));
        checkOutput("after_tail_grant_id", 128'(grantId), 128'(3));
        idleCycles(2);

        // Exhaust VC 0: 16 accepts, then five stalled cycles, then a single
        // credit return gives exactly one more accept in the next cycle.
        doReset();
        repeat (16) applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        repeat (5)  applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
`ifdef INJ_STALL_CNT_EN
        checkOutput("stall_cycles", 128'(stallCycles), 128'(5));
`endif
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleCycles(2);

        // Same-cycle send and return on VC 0 leaves one credit behind, so
        // exactly one further accept is possible.
        doReset();
        repeat (15) applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
        idleCycles(1);

        // Credit returns on a full VC 1 are dropped: still exactly 16 accepts.
        repeat (3)  applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0);
        repeat (16) applyStimulus(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1);
        idleCycles(2);

        // Reset in the middle of a packet after its third flit.
        doReset();
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1);
        checkOutput("mid_packet_busy", 128'(busy), 128'(1));
        reset = 1'b1;
        #3;
        checkOutput("ready_during_reset", 128'(reqReady), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("post_reset_busy", 128'(busy), 128'(0));
        checkOutput("post_reset_EN_putFlit", 128'(enPutFlit), 128'(0));
        checkOutput("post_reset_putFlit", 128'(putFlit), 128'(0));
        checkOutput("post_reset_grant_id", 128'(grantId), 128'(0));
        reset = 1'b0;
        applyStimulus(4'b0111, 4'b0111, 4'b0111, 1'b0, 1'b0, 4'b0001, 1'b1);
        repeat (15) applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1);
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b1);
        idleCycles(3);

        checkOutput("scoreboard_empty", 128'(expQ.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
